// File: rtl/intra_pkg.sv
// Shared parameters and FSM encoding for the 4x4 intra reconstruction block.
package intra_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned RESID_W  = 9;
  localparam int unsigned BLK_DIM  = 4;
  localparam int unsigned NUM_SMP  = BLK_DIM * BLK_DIM;
  localparam int unsigned SUM_W    = RESID_W + 1;
  localparam int unsigned ROW_W    = SAMPLE_W * BLK_DIM;
  localparam int unsigned BLK_W    = SAMPLE_W * NUM_SMP;
  localparam int unsigned RBLK_W   = RESID_W * NUM_SMP;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // Pick row i (4 samples, col0 in the low byte) out of a raster-packed block.
  function automatic logic [ROW_W-1:0] row_sel(input logic [BLK_W-1:0] blk, input logic [1:0] i);
    return blk[{i, 5'd0} +: ROW_W];
  endfunction

endpackage

// File: rtl/recon_clip.sv
// One-sample reconstruction: unsigned 8-bit pred plus signed 9-bit residual,
// clipped to 0..255.
//   pred   : predicted sample
//   resid  : two's complement residual (-256..255)
//   sample : reconstructed, clipped sample
module recon_clip import intra_pkg::*; (
  input  logic [SAMPLE_W-1:0] pred,
  input  logic [RESID_W-1:0]  resid,
  output logic [SAMPLE_W-1:0] sample
);

  logic signed [SUM_W-1:0] sum_c;

  // Sum range is -256..510, so 10 signed bits never overflow.
  always_comb begin
    sum_c = $signed({{(SUM_W-SAMPLE_W){1'b0}}, pred}) + $signed({resid[RESID_W-1], resid});
    if (sum_c[SUM_W-1]) begin
      sample = '0;
    end else if (sum_c[SAMPLE_W]) begin
      sample = '1;
    end else begin
      sample = sum_c[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/intra4x4_recon.sv
// 4x4 intra block reconstruction: accepts a prediction+residual block, emits
// four clipped rows over a valid/ready handshake, then publishes the block's
// bottom row, right column and corner sample as neighbours for the next block.
//   clk, reset          : clock, synchronous active-low reset
//   in_valid/in_ready   : block input handshake (pred, resid)
//   out_valid/out_ready : row output handshake (out_row, out_row_idx, out_last)
//   nb_valid            : one-cycle pulse when nb_bottom/nb_right/nb_corner update
module intra4x4_recon import intra_pkg::*; (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLK_W-1:0]   pred,
  input  logic [RBLK_W-1:0]  resid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic [1:0]         out_row_idx,
  output logic               out_last,
  output logic               nb_valid,
  output logic [ROW_W-1:0]   nb_bottom,
  output logic [ROW_W-1:0]   nb_right,
  output logic [SAMPLE_W-1:0] nb_corner
);

  logic [1:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [BLK_W-1:0]    pred_q, pred_d;
  logic [RBLK_W-1:0]   resid_q, resid_d;
  logic [BLK_W-1:0]    recon_q, recon_d;
  logic [BLK_W-1:0]    clip_c;
  logic                out_valid_q, out_valid_d;
  logic [ROW_W-1:0]    out_row_q, out_row_d;
  logic [1:0]          out_row_idx_q, out_row_idx_d;
  logic                out_last_q, out_last_d;
  logic                nb_valid_q, nb_valid_d;
  logic [ROW_W-1:0]    nb_bottom_q, nb_bottom_d;
  logic [ROW_W-1:0]    nb_right_q, nb_right_d;
  logic [SAMPLE_W-1:0] nb_corner_q, nb_corner_d;
  logic [1:0]          cnt_nx;

  // Sixteen add-and-clip lanes operating on the captured block operands.
  for (genvar k = 0; k < NUM_SMP; k++) begin : g_lane
    recon_clip u_clip (
      .pred   (pred_q[k*SAMPLE_W +: SAMPLE_W]),
      .resid  (resid_q[k*RESID_W +: RESID_W]),
      .sample (clip_c[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pred_d        = pred_q;
    resid_d       = resid_q;
    recon_d       = recon_q;
    out_valid_d   = out_valid_q;
    out_row_d     = out_row_q;
    out_row_idx_d = out_row_idx_q;
    out_last_d    = out_last_q;
    nb_valid_d    = 1'b0;
    nb_bottom_d   = nb_bottom_q;
    nb_right_d    = nb_right_q;
    nb_corner_d   = nb_corner_q;
    cnt_nx        = cnt_q + 2'd1;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pred_d  = pred;
          resid_d = resid;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        recon_d       = clip_c;
        cnt_d         = 2'd0;
        out_valid_d   = 1'b1;
        out_row_d     = row_sel(clip_c, 2'd0);
        out_row_idx_d = 2'd0;
        out_last_d    = 1'b0;
        state_d       = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (cnt_q == 2'd3) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            nb_valid_d  = 1'b1;
            nb_bottom_d = row_sel(recon_q, 2'd3);
            // Column 3 = samples 3, 7, 11, 15; row0 lands in the low byte.
            nb_right_d  = {recon_q[127:120], recon_q[95:88], recon_q[63:56], recon_q[31:24]};
            nb_corner_d = recon_q[127:120];
            state_d     = ST_IDLE;
          end else begin
            cnt_d         = cnt_nx;
            out_row_d     = row_sel(recon_q, cnt_nx);
            out_row_idx_d = cnt_nx;
            out_last_d    = (cnt_nx == 2'd3);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      pred_q        <= '0;
      resid_q       <= '0;
      recon_q       <= '0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_row_idx_q <= 2'd0;
      out_last_q    <= 1'b0;
      nb_valid_q    <= 1'b0;
      nb_bottom_q   <= '0;
      nb_right_q    <= '0;
      nb_corner_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pred_q        <= pred_d;
      resid_q       <= resid_d;
      recon_q       <= recon_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_row_idx_q <= out_row_idx_d;
      out_last_q    <= out_last_d;
      nb_valid_q    <= nb_valid_d;
      nb_bottom_q   <= nb_bottom_d;
      nb_right_q    <= nb_right_d;
      nb_corner_q   <= nb_corner_d;
    end
  end

  // Ready must drop combinationally while reset is held low.
  assign in_ready    = (state_q == ST_IDLE) && reset;
  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_row_idx = out_row_idx_q;
  assign out_last    = out_last_q;
  assign nb_valid    = nb_valid_q;
  assign nb_bottom   = nb_bottom_q;
  assign nb_right    = nb_right_q;
  assign nb_corner   = nb_corner_q;

endmodule

// File: tb/tb_intra4x4_recon.sv
// Self-checking bench for intra4x4_recon: directed vector table, randomized
// blocks against a plain-arithmetic model, stall / mid-block reset / queued
// block sequences.
module tb_intra4x4_recon;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pred;
  logic [143:0] resid;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_row;
  logic [1:0]   out_row_idx;
  logic         out_last;
  logic         nb_valid;
  logic [31:0]  nb_bottom;
  logic [31:0]  nb_right;
  logic [7:0]   nb_corner;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;
  int exp_pulses = 0;

  typedef struct {
    logic [127:0] p;
    logic [143:0] r;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[4];

  intra4x4_recon dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pred(pred), .resid(resid), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_row_idx(out_row_idx), .out_last(out_last),
    .nb_valid(nb_valid), .nb_bottom(nb_bottom), .nb_right(nb_right),
    .nb_corner(nb_corner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (nb_valid) pulses <= pulses + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: per-sample integer add then clamp to 0..255.
  function automatic logic [127:0] model(input logic [127:0] p, input logic [143:0] r);
    logic [127:0] o;
    int s;
    for (int k = 0; k < 16; k++) begin
      s = int'(p[8*k +: 8]) + int'($signed(r[9*k +: 9]));
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      o[8*k +: 8] = 8'(s);
    end
    return o;
  endfunction

  function automatic logic [31:0] col3(input logic [127:0] b);
    return {b[127:120], b[95:88], b[63:56], b[31:24]};
  endfunction

  // mode 0: ready high; 1: stall 3 cycles on row 1; 2: reset pulse on row 2.
  // hold: keep in_valid high after accept with (np, nr) queued behind.
  task automatic run_block(input logic [127:0] p, input logic [143:0] r,
                           input logic [127:0] exp, input int mode, input bit hold,
                           input logic [127:0] np, input logic [143:0] nr,
                           output int acc_cyc);
    int n;
    logic [31:0] er;
    in_valid = 1'b1; pred = p; resid = r; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin chk("in_ready_timeout", 128'(in_ready), 128'(1)); acc_cyc = 0; return; end
    acc_cyc = cyc + 1;
    @(negedge clk);
    if (hold) begin pred = np; resid = nr; end
    else begin
      in_valid = 1'b0;
      pred  = {$urandom, $urandom, $urandom, $urandom};
      resid = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    end
    chk("calc_out_valid", 128'(out_valid), 128'(0));
    chk("calc_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    for (int row = 0; row < 4; row++) begin
      er = exp[32*row +: 32];
      chk($sformatf("row%0d_valid", row), 128'(out_valid), 128'(1));
      chk($sformatf("row%0d_data", row), 128'(out_row), 128'(er));
      chk($sformatf("row%0d_idx", row), 128'(out_row_idx), 128'(row));
      chk($sformatf("row%0d_last", row), 128'(out_last), 128'(row == 3));
      chk($sformatf("row%0d_in_ready", row), 128'(in_ready), 128'(0));
      if (mode == 1 && row == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", 128'(out_valid), 128'(1));
          chk("stall_row", 128'(out_row), 128'(er));
          chk("stall_idx", 128'(out_row_idx), 128'(1));
          chk("stall_last", 128'(out_last), 128'(0));
        end
        out_ready = 1'b1;
      end
      if (mode == 2 && row == 2) begin
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_nb", {nb_bottom, nb_right, 8'(nb_corner)}, 128'(0));
        chk("rst_in_ready_low", 128'(in_ready), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_after", 128'(in_ready), 128'(1));
        chk("rst_out_valid_after", 128'(out_valid), 128'(0));
        repeat (6) @(negedge clk);
        chk("rst_no_rows", 128'(out_valid), 128'(0));
        return;
      end
      @(negedge clk);
    end
    exp_pulses++;
    chk("nb_valid", 128'(nb_valid), 128'(1));
    chk("end_out_valid", 128'(out_valid), 128'(0));
    chk("nb_bottom", 128'(nb_bottom), 128'(exp[127:96]));
    chk("nb_right", 128'(nb_right), 128'(col3(exp)));
    chk("nb_corner", 128'(nb_corner), 128'(exp[127:120]));
  endtask

  initial begin
    logic [127:0] rp, rp2;
    logic [143:0] rr, rr2;
    int acc, prev;

    reset = 1'b0; in_valid = 1'b0; pred = '0; resid = '0; out_ready = 1'b1;

    // Table: flat 0x80, ramp, clip corners.
    for (int k = 0; k < 16; k++) begin
      tbl[0].p[8*k +: 8] = 8'h80; tbl[0].r[9*k +: 9] = 9'd0;
      tbl[1].p[8*k +: 8] = 8'(k); tbl[1].r[9*k +: 9] = 9'd0;
      tbl[2].p[8*k +: 8] = 8'h10; tbl[2].r[9*k +: 9] = 9'd1;
    end
    tbl[2].p[7:0]   = 8'd250; tbl[2].r[8:0]   = 9'd10;
    tbl[2].p[15:8]  = 8'd5;   tbl[2].r[17:9]  = 9'h1F6;
    tbl[2].p[23:16] = 8'd255; tbl[2].r[26:18] = 9'h100;
    tbl[2].p[31:24] = 8'd100; tbl[2].r[35:27] = 9'h19C;
    tbl[3].p = '1; tbl[3].r = '0;
    for (int k = 0; k < 16; k++) tbl[3].r[9*k +: 9] = 9'd255;
    tbl[0].exp = {4{32'h80808080}};
    tbl[1].exp = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    tbl[2].exp = {32'h11111111, 32'h11111111, 32'h11111111, 32'h000000FF};
    tbl[3].exp = '1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_row", {out_row, 6'(out_row_idx), 1'(out_last)}, 128'(0));
    chk("rst_nb_valid", 128'(nb_valid), 128'(0));
    chk("rst_nb_regs", {nb_bottom, nb_right, 8'(nb_corner)}, 128'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'(1));

    prev = -1;
    for (int i = 0; i < 4; i++) begin
      run_block(tbl[i].p, tbl[i].r, tbl[i].exp, 0, 1'b0, '0, '0, acc);
      if (prev >= 0) chk("block_period", 128'(acc - prev), 128'(6));
      prev = acc;
    end
    if (nb_right !== 32'hFFFFFFFF) ; // no-op guard avoided; explicit check below
    chk("nb_hold_idle", 128'(nb_corner), 128'(8'hFF));

    // Stall on row 1.
    run_block(tbl[1].p, tbl[1].r, tbl[1].exp, 1, 1'b0, '0, '0, acc);

    // Two queued blocks with in_valid held high throughout.
    rp  = {$urandom, $urandom, $urandom, $urandom};
    rr  = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    rp2 = {$urandom, $urandom, $urandom, $urandom};
    rr2 = {16'($urandom), $urandom, $urandom, $urandom, $urandom};
    run_block(rp, rr, model(rp, rr), 0, 1'b1, rp2, rr2, prev);
    run_block(rp2, rr2, model(rp2, rr2), 0, 1'b0, '0, '0, acc);
    chk("queued_period", 128'(acc - prev), 128'(6));

    // Mid-block reset on row 2 (neighbours are nonzero beforehand).
    run_block(tbl[1].p, tbl[1].r, tbl[1].exp, 2, 1'b0, '0, '0, acc);
    chk("rst_pulses", 128'(pulses), 128'(exp_pulses));

    // Randomized blocks with extreme-biased residuals.
    for (int i = 0; i < 24; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 16; k++) begin
        case ($urandom_range(0, 3))
          0: rr[9*k +: 9] = 9'h100;
          1: rr[9*k +: 9] = 9'h0FF;
          default: rr[9*k +: 9] = 9'($urandom_range(0, 511));
        endcase
      end
      run_block(rp, rr, model(rp, rr), ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0, '0, '0, acc);
    end
    @(negedge clk);
    chk("nb_pulse_count", 128'(pulses), 128'(exp_pulses));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
